escritura_inicio: RTL and testbench

ESCRITURA_INICIO -- requirements
Module: escritura_inicio

---
 rtl/escritura_inicio.sv | 132 +++++++++++++
 tb/tb_escritura_inicio.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/escritura_inicio.sv
// Init write sequencer: walks an 8-entry address/data table onto a
// multiplexed bus, paced by an upstream 0..49 step counter.
module escritura_inicio (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] cuenta,
  output logic       en_cuenta,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       a_d,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       ocupado,
  output logic       listo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [2:0] idx, idx_nx;
  logic [7:0] addr, data;
  logic [7:0] out_nx;
  logic       oe_nx, ad_nx, strb_nx;

  always_comb begin
    addr = 8'h00;
    data = 8'h00;
    unique case (idx)
      3'd0: begin addr = 8'h02; data = 8'h10; end
      3'd1: begin addr = 8'h02; data = 8'h00; end
      3'd2: begin addr = 8'h10; data = 8'hD2; end
      3'd3: begin addr = 8'h21; data = 8'h00; end
      3'd4: begin addr = 8'h22; data = 8'h00; end
      3'd5: begin addr = 8'h23; data = 8'h00; end
      3'd6: begin addr = 8'h24; data = 8'h01; end
      3'd7: begin addr = 8'hF1; data = 8'h00; end
      default: begin addr = 8'h00; data = 8'h00; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = RUN;
          idx_nx   = 3'd0;
        end
      end
      RUN: begin
        if (cuenta == 6'd49) begin
          if (idx == 3'd7) state_nx = DONE;
          else idx_nx = idx + 3'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = 3'd0;
      end
    endcase
  end

  always_comb begin
    en_cuenta = (state == RUN);
    ocupado   = (state == RUN);
    listo     = (state == DONE);
  end

  // Next bus value; strobes only inside a driven phase, so cs_n low
  // always coincides with ad_oe high.
  always_comb begin
    out_nx  = 8'h00;
    oe_nx   = 1'b0;
    ad_nx   = 1'b0;
    strb_nx = 1'b0;
    if (state == RUN) begin
      unique case (1'b1)
        (cuenta <= 6'd14): begin
          oe_nx   = 1'b1;
          out_nx  = addr;
          strb_nx = (cuenta >= 6'd2) && (cuenta <= 6'd9);
        end
        (cuenta >= 6'd25) && (cuenta <= 6'd39): begin
          oe_nx   = 1'b1;
          ad_nx   = 1'b1;
          out_nx  = data;
          strb_nx = (cuenta >= 6'd27) && (cuenta <= 6'd34);
        end
        default: begin
          oe_nx   = 1'b0;
          strb_nx = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ad_out <= 8'h00;
      ad_oe  <= 1'b0;
      a_d    <= 1'b0;
      cs_n   <= 1'b1;
      wr_n   <= 1'b1;
    end else begin
      ad_out <= out_nx;
      ad_oe  <= oe_nx;
      a_d    <= ad_nx;
      cs_n   <= ~strb_nx;
      wr_n   <= ~strb_nx;
    end
  end

  assign rd_n = 1'b1;

endmodule

// File: tb/tb_escritura_inicio.sv
// Randomized bench for escritura_inicio against a transaction-level
// model of the init write sequence and the upstream step counter.
module tb_escritura_inicio;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [5:0] cuenta;
  logic       en_cuenta, ad_oe, a_d;
  logic       cs_n, wr_n, rd_n, ocupado, listo;
  logic [7:0] ad_out;

  escritura_inicio dut (
    .clk(clk), .reset(reset), .start(start), .cuenta(cuenta),
    .en_cuenta(en_cuenta), .ad_out(ad_out), .ad_oe(ad_oe), .a_d(a_d),
    .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
    .ocupado(ocupado), .listo(listo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] out;
    logic       oe, ad, cs, wr;
  } bus_t;

  byte unsigned addr_t[8] = '{8'h02, 8'h02, 8'h10, 8'h21, 8'h22, 8'h23, 8'h24, 8'hF1};
  byte unsigned data_t[8] = '{8'h10, 8'h00, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};

  int   total = 0, bad = 0;
  bit   chk_on = 0;
  bit   m_run = 0, m_done = 0, en_prev = 0;
  int   m_idx = 0, cur_c = 0;
  bus_t m_bus;
  int   plen = 0, pulses = 0, badlen = 0, run_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // What one bus cycle should look like for step c of entry i.
  function automatic bus_t decode(bit run, int i, int c);
    bus_t b;
    b = '{out: 8'h00, oe: 1'b0, ad: 1'b0, cs: 1'b1, wr: 1'b1};
    if (run) begin
      if (c < 15) begin
        b.oe = 1'b1;
        b.out = addr_t[i];
      end else if (c >= 25 && c < 40) begin
        b.oe = 1'b1;
        b.ad = 1'b1;
        b.out = data_t[i];
      end
      if ((c >= 2 && c <= 9) || (c >= 27 && c <= 34)) begin
        b.cs = 1'b0;
        b.wr = 1'b0;
      end
    end
    return b;
  endfunction

  task automatic cycle(input bit st, input bit rs,
                       input bit frc = 0, input int fv = 0);
    @(negedge clk);
    if (chk_on) begin
      chk("en_cuenta", en_cuenta, m_run);
      chk("ocupado", ocupado, m_run);
      chk("listo", listo, m_done);
      chk("ad_out", ad_out, m_bus.out);
      chk("ad_oe", ad_oe, m_bus.oe);
      chk("a_d", a_d, m_bus.ad);
      chk("cs_n", cs_n, m_bus.cs);
      chk("wr_n", wr_n, m_bus.wr);
      chk("rd_n", rd_n, 1);
      if (cs_n === 1'b0) chk("cs_oe", ad_oe, 1);
      if (cs_n === 1'b0) plen++;
      else if (plen > 0) begin
        pulses++;
        if (plen != 8) badlen++;
        plen = 0;
      end
      if (ocupado === 1'b1) run_cyc++;
    end
    if (frc) cur_c = fv;
    else if (en_prev) cur_c = (cur_c >= 49) ? 0 : cur_c + 1;
    else cur_c = 0;
    start  = st;
    reset  = rs;
    cuenta = 6'(cur_c);
    en_prev = m_run;
    if (rs) begin
      m_bus = decode(0, 0, 0);
      m_run = 0;
      m_done = 0;
      m_idx = 0;
    end else begin
      m_bus = decode(m_run, m_idx, cur_c);
      if (m_run) begin
        if (cur_c == 49) begin
          if (m_idx == 7) begin
            m_run = 0;
            m_done = 1;
          end else m_idx++;
        end
      end else if (st) begin
        m_run = 1;
        m_done = 0;
        m_idx = 0;
      end
    end
  endtask

  task automatic run_to_done(input bit st);
    int k;
    k = 0;
    while (!m_done && k < 1000) begin
      cycle(st, 0);
      k++;
    end
    chk("done_timeout", k < 1000, 1);
  endtask

  initial begin
    start = 0;
    reset = 1;
    cuenta = 0;
    cycle(0, 1);
    cycle(0, 1);
    chk_on = 1;
    cycle(0, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_ad_oe", ad_oe, 0);
    chk("rst_ocupado", ocupado, 0);

    pulses = 0; badlen = 0; run_cyc = 0; plen = 0;
    repeat ($urandom_range(1, 5)) cycle(0, 0);
    cycle(1, 0);
    run_to_done(0);
    repeat (3) cycle(0, 0);
    chk("run_cycles", run_cyc, 400);
    chk("pulse_count", pulses, 16);
    chk("pulse_len_bad", badlen, 0);
    chk("listo_end", listo, 1);
    chk("en_end", en_cuenta, 0);

    run_cyc = 0;
    cycle(1, 0);
    run_to_done(1);
    cycle(1, 0);
    chk("held_run_cycles", run_cyc, 400);
    cycle(1, 0);
    chk("restart_listo", listo, 0);
    chk("restart_ocup", ocupado, 1);

    for (int k = 0; k < 2000 && !(m_idx == 3 && cur_c == 4); k++)
      cycle(0, 0);
    cycle(0, 1);
    cycle(0, 0);
    chk("mid_rst_cs_n", cs_n, 1);
    chk("mid_rst_wr_n", wr_n, 1);
    chk("mid_rst_ad_oe", ad_oe, 0);
    chk("mid_rst_ocup", ocupado, 0);

    cycle(1, 0);
    for (int j = 0; j < 6; j++) begin
      repeat ($urandom_range(5, 120)) cycle(0, 0);
      repeat ($urandom_range(1, 4)) cycle(0, 0, 1, $urandom_range(50, 63));
    end
    run_to_done(0);
    cycle(0, 0);
    chk("force_done", listo, 1);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom % 200 == 0)
        cycle(0, 0, 1, $urandom_range(50, 63));
      else
        cycle($urandom % 8 == 0, $urandom % 300 == 0);
    end
    cycle(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
